// File: rtl/pulse_ext_pkg.sv
// Shared types and widths for the pulse-extend receiver.
package pulse_ext_pkg;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int MIN_HIGH_DEF    = 2;
  localparam int HCNT_W          = 4;
  localparam int PCNT_W          = 8;

  typedef enum logic [1:0] {ARM, IDLE, QUAL, ACK} state_t;
endpackage

// File: rtl/bit_sync.sv
// Single-bit multi-flop synchronizer with synchronous active-low reset.
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] sync_pipe;

  always_ff @(posedge clk) begin
    if (!rst_n) sync_pipe <= '0;
    else        sync_pipe <= {sync_pipe[STAGES-2:0], d};
  end

  assign q = sync_pipe[STAGES-1];
endmodule

// File: rtl/pulse_extend_rx.sv
// Receive side of a stretched-pulse CDC: synchronize, qualify by width,
// emit one pulse per qualified event and return a level acknowledge.
module pulse_extend_rx
  import pulse_ext_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int MIN_HIGH    = MIN_HIGH_DEF
) (
  input  logic              clk_b,
  input  logic              rstb_b,
  input  logic              ext_in,
  output logic              pulse_out,
  output logic              ack_out,
  output logic              glitch_err,
  output logic [PCNT_W-1:0] pulse_cnt
);
  localparam logic [HCNT_W-1:0] MIN_Q = HCNT_W'(MIN_HIGH);

  logic                    sync_q;
  logic [SYNC_STAGES-1:0]  vld_pipe;
  logic                    sync_ok;
  state_t                  state, state_nxt;
  logic [HCNT_W-1:0]       hcnt, hcnt_nxt, hcnt_inc;
  logic                    qual;
  logic                    pulse_nxt, ack_nxt, glitch_nxt;
  logic [PCNT_W-1:0]       cnt_nxt;

  bit_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk_b),
    .rst_n (rstb_b),
    .d     (ext_in),
    .q     (sync_q)
  );

  // The chain resets to 0, so a low sync_q right after reset is not a real
  // low; ARM only trusts sync_q once the chain has refilled from ext_in.
  always_ff @(posedge clk_b) begin
    if (!rstb_b) vld_pipe <= '0;
    else         vld_pipe <= {vld_pipe[SYNC_STAGES-2:0], 1'b1};
  end
  assign sync_ok = vld_pipe[SYNC_STAGES-1];

  assign hcnt_inc = hcnt + 1'b1;
  assign qual = sync_q && (((state == IDLE) && (MIN_HIGH == 1)) ||
                           ((state == QUAL) && (hcnt_inc >= MIN_Q)));

  always_ff @(posedge clk_b) begin
    if (!rstb_b) state <= ARM;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ARM:  if (sync_ok && !sync_q) state_nxt = IDLE;
      IDLE: if (sync_q)             state_nxt = qual ? ACK : QUAL;
      QUAL: if (!sync_q)            state_nxt = IDLE;
            else if (qual)          state_nxt = ACK;
      ACK:  if (!sync_q)            state_nxt = IDLE;
      default:                      state_nxt = ARM;
    endcase
  end

  always_comb begin
    pulse_nxt  = qual;
    glitch_nxt = (state == QUAL) && !sync_q;
    ack_nxt    = qual || ((state == ACK) && sync_q);
    cnt_nxt    = pulse_cnt + PCNT_W'(qual);
    hcnt_nxt   = hcnt;
    if (sync_q && (state == IDLE))      hcnt_nxt = HCNT_W'(1);
    else if (sync_q && (state == QUAL)) hcnt_nxt = hcnt_inc;
  end

  always_ff @(posedge clk_b) begin
    if (!rstb_b) begin
      hcnt       <= '0;
      pulse_out  <= 1'b0;
      ack_out    <= 1'b0;
      glitch_err <= 1'b0;
      pulse_cnt  <= '0;
    end else begin
      hcnt       <= hcnt_nxt;
      pulse_out  <= pulse_nxt;
      ack_out    <= ack_nxt;
      glitch_err <= glitch_nxt;
      pulse_cnt  <= cnt_nxt;
    end
  end
endmodule

// File: tb/tb_pulse_extend_rx.sv
// Directed bench for pulse_extend_rx: default instance plus a MIN_HIGH=1 instance.
module tb_pulse_extend_rx;
  import pulse_ext_pkg::*;

  logic       clk_b = 1'b0;
  logic       rstb_b = 1'b0;
  logic       ext_in = 1'b0;
  logic       ext1 = 1'b0;
  logic       pulse_out, ack_out, glitch_err;
  logic [7:0] pulse_cnt;
  logic       pulse1, ack1, glitch1;
  logic [7:0] cnt1;

  int checks = 0;
  int failures = 0;
  int pulses0 = 0, glitches0 = 0, pulses1 = 0;

  typedef struct {
    logic       is_pulse;
    logic [7:0] cnt;
  } exp_t;
  exp_t       sb[$];
  logic [7:0] model_cnt = 8'd0;

  always #5 clk_b = ~clk_b;

  pulse_extend_rx dut (
    .clk_b(clk_b), .rstb_b(rstb_b), .ext_in(ext_in),
    .pulse_out(pulse_out), .ack_out(ack_out), .glitch_err(glitch_err), .pulse_cnt(pulse_cnt)
  );

  pulse_extend_rx #(.SYNC_STAGES(2), .MIN_HIGH(1)) dut1 (
    .clk_b(clk_b), .rstb_b(rstb_b), .ext_in(ext1),
    .pulse_out(pulse1), .ack_out(ack1), .glitch_err(glitch1), .pulse_cnt(cnt1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_b);
    #1;
  endtask

  task automatic push_pulse;
    model_cnt++;
    sb.push_back('{1'b1, model_cnt});
  endtask

  task automatic push_glitch;
    sb.push_back('{1'b0, model_cnt});
  endtask

  task automatic send(input int len, input int gap);
    if (len >= 2) push_pulse();
    else          push_glitch();
    ext_in = 1'b1;
    repeat (len) tick();
    ext_in = 1'b0;
    repeat (gap) tick();
  endtask

  // Output monitor: every pulse/glitch must match the oldest expected event.
  always @(negedge clk_b) begin
    exp_t e;
    if (pulse_out)  pulses0++;
    if (glitch_err) glitches0++;
    if (pulse1)     pulses1++;
    if (pulse_out || glitch_err) begin
      if (sb.size() == 0) chk("unexpected_event", {30'd0, pulse_out, glitch_err}, 32'd0);
      else begin
        e = sb.pop_front();
        chk("event_kind", {30'd0, pulse_out, glitch_err}, e.is_pulse ? 32'd2 : 32'd1);
        if (pulse_out) chk("cnt_at_pulse", 32'(pulse_cnt), 32'(e.cnt));
      end
    end
    if (glitch1) chk("mh1_glitch", 32'(glitch1), 32'd0);
  end

  initial begin
    int p0, g0;

    // Reset state
    rstb_b = 1'b0;
    repeat (3) tick();
    chk("rst_pulse",  32'(pulse_out), 32'd0);
    chk("rst_ack",    32'(ack_out), 32'd0);
    chk("rst_glitch", 32'(glitch_err), 32'd0);
    chk("rst_cnt",    32'(pulse_cnt), 32'd0);
    chk("rst_state",  32'(dut.state), 32'(ARM));
    rstb_b = 1'b1;
    repeat (3) tick();
    chk("arm_to_idle", 32'(dut.state), 32'(IDLE));

    // 6-cycle pulse: latency, ack timing
    push_pulse();
    ext_in = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk($sformatf("lat_pulse_e%0d", i), 32'(pulse_out), (i == 4) ? 32'd1 : 32'd0);
      chk($sformatf("lat_ack_e%0d", i), 32'(ack_out), (i >= 4) ? 32'd1 : 32'd0);
    end
    chk("cnt_after_first", 32'(pulse_cnt), 32'd1);
    ext_in = 1'b0;
    tick(); chk("ack_fall_e1", 32'(ack_out), 32'd1);
    tick(); chk("ack_fall_e2", 32'(ack_out), 32'd1);
    tick(); chk("ack_fall_e3", 32'(ack_out), 32'd0);
    tick();

    // 1-cycle glitch
    push_glitch();
    ext_in = 1'b1;
    tick();
    ext_in = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("glitch_ack_low", 32'(ack_out), 32'd0);
    end
    chk("glitch_cnt_kept", 32'(pulse_cnt), 32'd1);
    chk("glitch_seen", 32'(glitches0), 32'd1);

    // Mixed widths
    send(2, 3); send(3, 4); send(1, 3); send(8, 2); send(5, 5);
    repeat (4) tick();
    chk("mix_cnt", 32'(pulse_cnt), 32'(model_cnt));
    chk("mix_sb_empty", sb.size(), 32'd0);

    // Level held high with sub-cycle drops: exactly one pulse
    push_pulse();
    ext_in = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (i == 10 || i == 20) begin
        ext_in = 1'b0;
        #2 ext_in = 1'b1;
      end
    end
    chk("held_ack", 32'(ack_out), 32'd1);
    ext_in = 1'b0;
    repeat (5) tick();
    chk("held_cnt", 32'(pulse_cnt), 32'(model_cnt));

    // MIN_HIGH=1 instance
    ext1 = 1'b1;
    tick(); chk("mh1_e1", 32'(pulse1), 32'd0);
    ext1 = 1'b0;
    tick(); chk("mh1_e2", 32'(pulse1), 32'd0);
    tick(); chk("mh1_e3", 32'(pulse1), 32'd1);
    chk("mh1_ack_rise", 32'(ack1), 32'd1);
    tick(); chk("mh1_e4", 32'(pulse1), 32'd0);
    chk("mh1_ack_fall", 32'(ack1), 32'd0);
    repeat (2) begin
      ext1 = 1'b1; tick(); ext1 = 1'b0; repeat (4) tick();
    end
    chk("mh1_pulses", pulses1, 32'd3);
    chk("mh1_cnt", 32'(cnt1), 32'd3);

    // ext_in held through reset release: ARM must wait for a low
    ext_in = 1'b1;
    rstb_b = 1'b0;
    model_cnt = 8'd0;
    repeat (3) tick();
    rstb_b = 1'b1;
    repeat (10) tick();
    chk("held_rst_state", 32'(dut.state), 32'(ARM));
    chk("held_rst_cnt", 32'(pulse_cnt), 32'd0);
    ext_in = 1'b0;
    repeat (4) tick();
    chk("held_rst_idle", 32'(dut.state), 32'(IDLE));
    send(6, 4);
    chk("held_rst_next_cnt", 32'(pulse_cnt), 32'd1);

    // Reset one cycle into ACK
    push_pulse();
    ext_in = 1'b1;
    repeat (4) tick();
    chk("ack_rst_pulse", 32'(pulse_out), 32'd1);
    tick();
    rstb_b = 1'b0;
    model_cnt = 8'd0;
    tick();
    chk("ack_rst_ack", 32'(ack_out), 32'd0);
    chk("ack_rst_state", 32'(dut.state), 32'(ARM));
    chk("ack_rst_cnt", 32'(pulse_cnt), 32'd0);
    rstb_b = 1'b1;
    repeat (6) tick();
    ext_in = 1'b0;
    repeat (5) tick();

    // Reset mid-QUAL aborts without a pulse
    p0 = pulses0;
    ext_in = 1'b1;
    repeat (3) tick();
    chk("qual_reached", 32'(dut.state), 32'(QUAL));
    rstb_b = 1'b0;
    tick();
    ext_in = 1'b0;
    chk("qual_rst_state", 32'(dut.state), 32'(ARM));
    rstb_b = 1'b1;
    repeat (5) tick();
    chk("qual_rst_nopulse", pulses0 - p0, 32'd0);
    chk("qual_rst_cnt", 32'(pulse_cnt), 32'd0);

    // 257 qualified pulses: counter wraps
    p0 = pulses0;
    g0 = glitches0;
    repeat (257) send(2, 3);
    repeat (4) tick();
    chk("wrap_cnt", 32'(pulse_cnt), 32'd1);
    chk("wrap_pulses", pulses0 - p0, 32'd257);
    chk("wrap_no_glitch", glitches0 - g0, 32'd0);
    chk("final_sb_empty", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pulse_extend_rx.md
PULSE_EXTEND_RX -- requirements
Module: pulse_extend_rx

Interface
REQ-001 Parameter: SYNC_STAGES, default 2, number of synchronizer flops on ext_in; legal range 2..4.
REQ-002 Parameter: MIN_HIGH, default 2, consecutive synchronized-high samples that qualify a pulse; legal range 1..15.
REQ-003 Port: clk_b  input  1  receive-domain clock; the only clock of the block.
REQ-004 Port: rstb_b  input  1  reset, synchronous to clk_b, active-low.
REQ-005 Port: ext_in  input  1  stretched pulse from the sending domain; asynchronous to clk_b.
REQ-006 Port: pulse_out  output  1  single-cycle pulse, one per qualified ext_in pulse.
REQ-007 Port: ack_out  output  1  level acknowledge returned to the sending domain.
REQ-008 Port: glitch_err  output  1  single-cycle flag: ext_in high too short to qualify.
REQ-009 Port: pulse_cnt  output  8  count of qualified pulses, modulo 256.

Function
REQ-010 ext_in SHALL pass through a SYNC_STAGES-deep flop chain; only its last stage (sync_q) SHALL feed the block's logic.
REQ-011 FSM states SHALL be ARM, IDLE, QUAL, ACK; all outputs SHALL be registered.
REQ-012 ARM: stay while sync_q=1; go to IDLE on the first sample with sync_q=0.
REQ-013 IDLE: on sync_q=1, go to QUAL and load the 4-bit high counter with 1; otherwise stay.
REQ-014 QUAL, sync_q=1: increment the counter; once the count reaches MIN_HIGH, assert pulse_out for one cycle, set ack_out=1, increment pulse_cnt, go to ACK.
REQ-015 QUAL, sync_q=0 before MIN_HIGH is reached: assert glitch_err for one cycle, go to IDLE; pulse_cnt and ack_out unchanged.
REQ-016 MIN_HIGH=1: the first high sample qualifies immediately from IDLE; QUAL is never held; glitch_err never asserts.
REQ-017 ACK: hold ack_out=1 while sync_q=1; on sync_q=0, clear ack_out and go to IDLE.
REQ-018 Latency: pulse_out SHALL rise after the (SYNC_STAGES+MIN_HIGH)th rising edge of clk_b at which ext_in is high, counting the capturing edge as the first.
REQ-019 ack_out SHALL rise in the same cycle as pulse_out and fall one cycle after sync_q is first sampled low in ACK.
REQ-020 pulse_out and glitch_err SHALL never be high in the same cycle; each SHALL be high for exactly one cycle per event.
REQ-021 pulse_cnt SHALL wrap 255 -> 0 without any flag.
REQ-022 An ext_in level held high indefinitely SHALL produce exactly one pulse_out.
REQ-023 A new ext_in rise while in ACK (sync_q never low) SHALL NOT generate a second pulse.

Reset
REQ-024 With rstb_b=0 at a clk_b edge: synchronizer flops, counter, pulse_out, ack_out, glitch_err and pulse_cnt SHALL become 0, and the state SHALL become ARM.
REQ-025 A reset asserted mid-pulse (QUAL or ACK) SHALL abort the pulse with no pulse_out; if ext_in is still high after release, the pulse SHALL NOT be counted (ARM waits for low).
REQ-026 A pulse with ext_in low for at least SYNC_STAGES cycles after reset release SHALL be processed normally.

Structure
REQ-027 Package pulse_ext_pkg SHALL hold the FSM state enum, the default values of SYNC_STAGES and MIN_HIGH, and the counter widths (4-bit high counter, 8-bit pulse_cnt).
REQ-028 The synchronizer chain SHALL be a separate sub-module, bit_sync, parameterized by stage count, with a synchronous active-low reset.

Verification
REQ-029 Defaults, ext_in high for 6 cycles -> pulse_out high for exactly 1 cycle after the 4th sampling edge; pulse_cnt=1; ack_out high until 3 edges after ext_in falls.
REQ-030 Defaults, ext_in high for 1 cycle -> glitch_err 1 cycle, no pulse_out, pulse_cnt=0, ack_out stays 0.
REQ-031 MIN_HIGH=1, 1-cycle ext_in -> pulse_out 1 cycle, glitch_err never asserts.
REQ-032 ext_in held high through reset release -> no pulse_out until ext_in goes low then high again; the following 6-cycle pulse gives pulse_cnt=1.
REQ-033 Reset asserted 1 cycle into ACK -> ack_out=0 and state ARM on the next edge; pulse_cnt=0.
REQ-034 Send 257 qualified pulses -> pulse_cnt=1; pulse_out count=257; no glitch_err.
